feature_pool_stage: RTL

//  Parametrised fused activation + spatial pooling stage; next generation of the extractor back end.

---
 rtl/feature_pool_stage.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/feature_pool_stage.sv
// Fused activation + POOLxPOOL max/average pooling over a raster-order signed pixel stream.
// Emits one pooled result per complete window and a one-cycle done pulse at frame end.
module feature_pool_stage #(
  parameter int unsigned DATA_W      = 22,
  parameter int unsigned IMG_WIDTH   = 30,
  parameter int unsigned IMG_HEIGHT  = 30,
  parameter int unsigned POOL        = 2,
  parameter int unsigned LEAKY_SHIFT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_signal,
  input  logic [1:0]               act_mode,
  input  logic                     pool_mode,
  input  logic                     pixel_valid,
  input  logic signed [DATA_W-1:0] pixel_in,
  output logic signed [DATA_W-1:0] result_out,
  output logic                     result_valid,
  output logic                     done_signal,
  output logic                     busy,
  output logic                     err_overrun
);

  localparam int unsigned LOG2P    = $clog2(POOL);
  localparam int unsigned ACC_W    = DATA_W + 2 * LOG2P;
  localparam int unsigned OUT_COLS = IMG_WIDTH / POOL;
  localparam int unsigned OUT_ROWS = IMG_HEIGHT / POOL;
  localparam int unsigned V_COLS   = OUT_COLS * POOL;
  localparam int unsigned V_ROWS   = OUT_ROWS * POOL;
  localparam int unsigned COL_W    = $clog2(IMG_WIDTH + 1);
  localparam int unsigned ROW_W    = $clog2(IMG_HEIGHT + 1);
  localparam int unsigned IDX_W    = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [COL_W-1:0]          r_col;
  logic [ROW_W-1:0]          r_row;
  logic [1:0]                r_act_mode;
  logic                      r_pool_mode;
  logic signed [ACC_W-1:0]   r_hacc;
  logic signed [ACC_W-1:0]   r_rowbuf [OUT_COLS];
  logic signed [DATA_W-1:0]  r_result;
  logic                      r_result_valid;
  logic                      r_done;
  logic                      r_busy;
  logic                      r_err;

  logic                      w_run;
  logic                      w_restart;
  logic                      w_accept;
  logic                      w_last_col;
  logic                      w_last_row;
  logic                      w_frame_end;
  logic signed [DATA_W-1:0]  w_act;
  logic signed [ACC_W-1:0]   w_act_ext;
  logic [LOG2P-1:0]          w_pc;
  logic [LOG2P-1:0]          w_pr;
  logic                      w_in_win;
  logic                      w_hend;
  logic                      w_vend;
  logic [IDX_W-1:0]          w_idx;
  logic signed [ACC_W-1:0]   w_hnew;
  logic signed [ACC_W-1:0]   w_vnew;
  logic                      w_emit;
  logic signed [DATA_W-1:0]  w_result;

  function automatic logic signed [ACC_W-1:0] f_merge(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b,
    input logic                    avg
  );
    if (avg) begin
      return a + b;
    end
    return (a > b) ? a : b;
  endfunction

  assign w_run       = (r_state == S_RUN);
  // start aborts RUN and wins over a same-cycle pixel; it is ignored in DONE
  assign w_restart   = start_signal && (r_state != S_DONE);
  assign w_accept    = pixel_valid && w_run && !start_signal;
  assign w_last_col  = (r_col == COL_W'(IMG_WIDTH - 1));
  assign w_last_row  = (r_row == ROW_W'(IMG_HEIGHT - 1));
  assign w_frame_end = w_accept && w_last_col && w_last_row;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start_signal) w_state_nxt = S_RUN;
      S_RUN: begin
        if (start_signal) begin
          w_state_nxt = S_RUN;
        end else if (w_frame_end) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // activation on the accepted pixel, using the modes latched at frame start
  always_comb begin
    w_act = pixel_in;
    case (r_act_mode)
      2'd0:    w_act = pixel_in;
      2'd2:    w_act = pixel_in[DATA_W-1] ? (pixel_in >>> LEAKY_SHIFT) : pixel_in;
      default: w_act = pixel_in[DATA_W-1] ? '0 : pixel_in;
    endcase
  end

  assign w_act_ext = {{(2 * LOG2P){w_act[DATA_W-1]}}, w_act};

  assign w_pc     = r_col[LOG2P-1:0];
  assign w_pr     = r_row[LOG2P-1:0];
  assign w_in_win = (r_col < COL_W'(V_COLS)) && (r_row < ROW_W'(V_ROWS));
  assign w_hend   = (w_pc == LOG2P'(POOL - 1));
  assign w_vend   = (w_pr == LOG2P'(POOL - 1));
  assign w_idx    = IDX_W'(r_col >> LOG2P);

  // first pixel of a row segment / first segment of a window overwrites instead of merging
  assign w_hnew = (w_pc == '0) ? w_act_ext : f_merge(r_hacc, w_act_ext, r_pool_mode);
  assign w_vnew = (w_pr == '0) ? w_hnew : f_merge(r_rowbuf[w_idx], w_hnew, r_pool_mode);

  assign w_emit   = w_accept && w_in_win && w_hend && w_vend;
  // average: the top DATA_W bits are the floor of sum >>> 2*log2(POOL)
  assign w_result = r_pool_mode ? w_vnew[ACC_W-1 -: DATA_W] : w_vnew[DATA_W-1:0];

  // control, counters, and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col          <= '0;
      r_row          <= '0;
      r_act_mode     <= '0;
      r_pool_mode    <= 1'b0;
      r_hacc         <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_done         <= 1'b0;
      r_busy         <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_result_valid <= w_emit;
      r_done         <= w_frame_end;
      r_busy         <= (w_state_nxt == S_RUN);
      if (w_emit) begin
        r_result <= w_result;
      end
      if (w_accept && w_in_win && !w_hend) begin
        r_hacc <= w_hnew;
      end
      if (w_restart) begin
        r_col       <= '0;
        r_row       <= '0;
        r_act_mode  <= act_mode;
        r_pool_mode <= pool_mode;
        r_err       <= 1'b0;
      end else begin
        if (pixel_valid && !w_run) begin
          r_err <= 1'b1;
        end
        if (w_accept) begin
          if (w_last_col) begin
            r_col <= '0;
            r_row <= w_last_row ? '0 : r_row + ROW_W'(1);
          end else begin
            r_col <= r_col + COL_W'(1);
          end
        end
      end
    end
  end

  // per-output-column partial vertical results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(OUT_COLS); i++) begin
        r_rowbuf[i] <= '0;
      end
    end else if (w_accept && w_in_win && w_hend && !w_vend) begin
      r_rowbuf[w_idx] <= w_vnew;
    end
  end

  assign result_out   = r_result;
  assign result_valid = r_result_valid;
  assign done_signal  = r_done;
  assign busy         = r_busy;
  assign err_overrun  = r_err;

endmodule
